// File: rtl/pe_pkg.sv
// Shared definitions for the PE operand feeder: default widths and FSM states.
package pe_pkg;

  localparam int DW_DEF = 16;
  localparam int CW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    START  = 3'd3,
    WAIT   = 3'd4
  } state_e;

endpackage

// File: rtl/pe_feeder.sv
// Operand loader for one systolic PE: streams host words into the A/B FIFOs, then starts the PE.
// Optional build macro PE_FEEDER_INTERLEAVE_EN merges the A/B load phases into one alternating LOAD.
module pe_feeder
  import pe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          go,
  input  logic [CW-1:0] cfg_len,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] a_in,
  output logic          awe,
  input  logic          aff,
  output logic [DW-1:0] b_in,
  output logic          bwe,
  input  logic          bff,
  output logic [CW-1:0] max_cntr,
  output logic          start,
  input  logic          se,
  output logic          busy,
  output logic          done
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] maxc_q, maxc_d;
  logic          done_q, done_d;
`ifdef PE_FEEDER_INTERLEAVE_EN
  logic          selB_q, selB_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      maxc_q  <= '0;
      done_q  <= 1'b0;
`ifdef PE_FEEDER_INTERLEAVE_EN
      selB_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      maxc_q  <= maxc_d;
      done_q  <= done_d;
`ifdef PE_FEEDER_INTERLEAVE_EN
      selB_q  <= selB_d;
`endif
    end
  end

  // Strobes are decoded from the current state so that reset silences them immediately.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    maxc_d   = maxc_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    awe      = 1'b0;
    bwe      = 1'b0;
    a_in     = '0;
    b_in     = '0;
    start    = 1'b0;
`ifdef PE_FEEDER_INTERLEAVE_EN
    selB_d   = selB_q;
`endif
    case (state_q)
      IDLE: begin
        if (go) begin
          maxc_d  = cfg_len;
          cnt_d   = '0;
          state_d = LOAD_A;
`ifdef PE_FEEDER_INTERLEAVE_EN
          selB_d  = 1'b0;
`endif
        end
      end
`ifdef PE_FEEDER_INTERLEAVE_EN
      // Merged load: the counter advances once per A/B word pair.
      LOAD_A: begin
        in_ready = selB_q ? ~bff : ~aff;
        if (in_valid && in_ready) begin
          if (!selB_q) begin
            awe    = 1'b1;
            a_in   = in_data;
            selB_d = 1'b1;
          end else begin
            bwe    = 1'b1;
            b_in   = in_data;
            selB_d = 1'b0;
            if (cnt_q == maxc_q) begin
              cnt_d   = '0;
              state_d = START;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
      end
`else
      LOAD_A: begin
        in_ready = ~aff;
        if (in_valid && !aff) begin
          awe  = 1'b1;
          a_in = in_data;
          if (cnt_q == maxc_q) begin
            cnt_d   = '0;
            state_d = LOAD_B;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      LOAD_B: begin
        in_ready = ~bff;
        if (in_valid && !bff) begin
          bwe  = 1'b1;
          b_in = in_data;
          if (cnt_q == maxc_q) begin
            cnt_d   = '0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`endif
      START: begin
        start   = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        if (se) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign max_cntr = maxc_q;

endmodule
